lwram_ctrl: RTL and testbench

LWRAM_CTRL -- requirements
Module: lwram_ctrl

---
 rtl/lwram_pkg.sv | 29 ++
 rtl/lwram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lwram_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lwram_pkg.sv
// rtl/lwram_pkg.sv - shared FSM state, byte-enable encoding and byte-merge helper for lwram_ctrl
package lwram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } state_t;

  // MEM_BE[1] enables the upper byte, MEM_BE[0] the lower byte
  localparam logic [1:0] BE_WORD  = 2'b11;
  localparam int         BE_UPPER = 1;
  localparam int         BE_LOWER = 0;

  // DWE_N strobes are active-low per byte, so the enable is their inverse
  function automatic logic [1:0] be_from_dwe(input logic [1:0] dwe_n);
    return ~dwe_n;
  endfunction

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_data,
                                              input logic [15:0] new_data,
                                              input logic [1:0]  be);
    logic [15:0] res;
    res[15:8] = be[BE_UPPER] ? new_data[15:8] : old_data[15:8];
    res[7:0]  = be[BE_LOWER] ? new_data[7:0]  : old_data[7:0];
    return res;
  endfunction

endpackage

// File: rtl/lwram_ctrl.sv
// rtl/lwram_ctrl.sv - LWRAM bridge with a posted write buffer and a one-word read buffer
module lwram_ctrl
  import lwram_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W:1]   A,
  input  logic [15:0]       DI,
  output logic [15:0]       DO,
  input  logic              DCE_N,
  input  logic              DOE_N,
  input  logic [1:0]        DWE_N,
  output logic              DWAIT_N,
  output logic              MEM_REQ,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [1:0]        MEM_BE,
  output logic [15:0]       MEM_WDATA,
  input  logic [15:0]       MEM_RDATA,
  input  logic              MEM_RDY
);

  state_t state, state_nx;

  logic              doe_n_d;
  logic              dwe_n_d;
  logic              rd_start;
  logic              wr_start;
  logic              rb_hit;
  logic              mem_done;
  logic              stall_eff;
  logic              pend_eff;

  logic              rb_valid;
  logic [ADDR_W-1:0] rb_addr;
  logic [15:0]       rb_data;
  logic              rd_pend;
  logic              wr_stall;

  logic              cap_wr;
  logic              iss_rd;
  logic              ld_hit;
  logic              rd_done;
  logic              mem_req_nx;
  logic              dwait_n_nx;
  logic              rd_pend_nx;
  logic              wr_stall_nx;

  assign rd_start = !DOE_N && doe_n_d && !DCE_N;
  assign wr_start = !(&DWE_N) && dwe_n_d && !DCE_N;
  assign rb_hit   = rb_valid && (rb_addr == A);
  assign mem_done = MEM_REQ && MEM_RDY;

  // A start landing on the completion cycle is served as if it had already been queued
  assign stall_eff = wr_stall || wr_start;
  assign pend_eff  = rd_pend || (rd_start && !wr_start);

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (wr_start)                 state_nx = WR_BUSY;
        else if (rd_start && !rb_hit) state_nx = RD_BUSY;
      end
      WR_BUSY: begin
        if (mem_done) begin
          if (stall_eff)     state_nx = WR_BUSY;
          else if (pend_eff) state_nx = rb_hit ? IDLE : RD_BUSY;
          else               state_nx = IDLE;
        end
      end
      RD_BUSY: begin
        if (mem_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // MEM_REQ always drops for one cycle after MEM_RDY; a busy state with MEM_REQ low re-raises it
  always_comb begin
    cap_wr      = 1'b0;
    iss_rd      = 1'b0;
    ld_hit      = 1'b0;
    rd_done     = 1'b0;
    mem_req_nx  = MEM_REQ;
    dwait_n_nx  = DWAIT_N;
    rd_pend_nx  = rd_pend;
    wr_stall_nx = wr_stall;
    case (state)
      IDLE: begin
        if (wr_start) begin
          cap_wr     = 1'b1;
          mem_req_nx = 1'b1;
        end else if (rd_start) begin
          if (rb_hit) begin
            ld_hit = 1'b1;
          end else begin
            iss_rd     = 1'b1;
            mem_req_nx = 1'b1;
            dwait_n_nx = 1'b0;
          end
        end
      end
      WR_BUSY: begin
        if (mem_done) begin
          mem_req_nx = 1'b0;
          if (stall_eff) begin
            cap_wr      = 1'b1;
            wr_stall_nx = 1'b0;
            dwait_n_nx  = !rd_pend;
          end else if (pend_eff) begin
            rd_pend_nx = 1'b0;
            if (rb_hit) begin
              ld_hit     = 1'b1;
              dwait_n_nx = 1'b1;
            end else begin
              iss_rd     = 1'b1;
              dwait_n_nx = 1'b0;
            end
          end
        end else begin
          if (!MEM_REQ) mem_req_nx = 1'b1;
          if (wr_start) begin
            wr_stall_nx = 1'b1;
            dwait_n_nx  = 1'b0;
          end else if (rd_start) begin
            rd_pend_nx = 1'b1;
            dwait_n_nx = 1'b0;
          end
        end
      end
      RD_BUSY: begin
        if (mem_done) begin
          rd_done    = 1'b1;
          mem_req_nx = 1'b0;
          dwait_n_nx = 1'b1;
        end else if (!MEM_REQ) begin
          mem_req_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      doe_n_d   <= 1'b1;
      dwe_n_d   <= 1'b1;
      MEM_REQ   <= 1'b0;
      MEM_WR    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_BE    <= '0;
      MEM_WDATA <= '0;
      DWAIT_N   <= 1'b1;
      DO        <= '0;
      rb_valid  <= 1'b0;
      rb_addr   <= '0;
      rb_data   <= '0;
      rd_pend   <= 1'b0;
      wr_stall  <= 1'b0;
    end else begin
      doe_n_d  <= DOE_N;
      dwe_n_d  <= &DWE_N;
      MEM_REQ  <= mem_req_nx;
      DWAIT_N  <= dwait_n_nx;
      rd_pend  <= rd_pend_nx;
      wr_stall <= wr_stall_nx;
      if (cap_wr) begin
        MEM_ADDR  <= A;
        MEM_BE    <= be_from_dwe(DWE_N);
        MEM_WDATA <= DI;
        MEM_WR    <= 1'b1;
        // Keep the read buffer coherent with the write that is about to be posted
        if (rb_hit) rb_data <= merge_bytes(rb_data, DI, be_from_dwe(DWE_N));
      end
      if (iss_rd) begin
        MEM_ADDR <= A;
        MEM_BE   <= BE_WORD;
        MEM_WR   <= 1'b0;
      end
      if (ld_hit) DO <= rb_data;
      if (rd_done) begin
        DO       <= MEM_RDATA;
        rb_valid <= 1'b1;
        rb_addr  <= MEM_ADDR;
        rb_data  <= MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_lwram_ctrl.sv
// tb/tb_lwram_ctrl.sv - scoreboard bench for lwram_ctrl with a fixed-latency memory model
module tb_lwram_ctrl;

  localparam int ADDR_W = 19;
  localparam int LAT    = 5;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [ADDR_W:1]   A;
  logic [15:0]       DI;
  logic [15:0]       DO;
  logic              DCE_N;
  logic              DOE_N;
  logic [1:0]        DWE_N;
  logic              DWAIT_N;
  logic              MEM_REQ;
  logic              MEM_WR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [1:0]        MEM_BE;
  logic [15:0]       MEM_WDATA;
  logic [15:0]       MEM_RDATA;
  logic              MEM_RDY;

  always #5 CLK = ~CLK;

  lwram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .DI(DI), .DO(DO),
    .DCE_N(DCE_N), .DOE_N(DOE_N), .DWE_N(DWE_N), .DWAIT_N(DWAIT_N),
    .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_RDY(MEM_RDY)
  );

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        be;
    logic [15:0]       wdata;
  } req_t;

  req_t        req_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] mem [int];
  int          checks    = 0;
  int          errors    = 0;
  int          req_rises = 0;
  bit          stray     = 1'b0;
  event        rd_done_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers LAT cycles after MEM_REQ rises; stray forces an unsolicited MEM_RDY
  initial begin
    int cnt = 0;
    int key;
    logic [15:0] old;
    MEM_RDY   = 1'b0;
    MEM_RDATA = 16'h0;
    forever begin
      @(posedge CLK);
      #2;
      MEM_RDY = 1'b0;
      if (stray) begin
        MEM_RDY   = 1'b1;
        MEM_RDATA = 16'hDEAD;
      end else if (MEM_REQ) begin
        cnt++;
        if (cnt >= LAT) begin
          cnt     = 0;
          MEM_RDY = 1'b1;
          key     = int'(MEM_ADDR);
          old     = mem.exists(key) ? mem[key] : 16'h0;
          if (MEM_WR) begin
            if (MEM_BE[1]) old[15:8] = MEM_WDATA[15:8];
            if (MEM_BE[0]) old[7:0]  = MEM_WDATA[7:0];
            mem[key] = old;
          end else begin
            MEM_RDATA = old;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Request monitor: every completed handshake must match the head of req_q
  initial begin
    bit   prev_req = 1'b0;
    bit   prev_rdy = 1'b0;
    req_t first;
    req_t exp;
    first = '0;
    forever begin
      @(negedge CLK);
      if (prev_rdy) check("req_low_after_rdy", MEM_REQ, 1'b0);
      if (MEM_REQ && !prev_req) begin
        req_rises++;
        first = '{MEM_WR, MEM_ADDR, MEM_BE, MEM_WDATA};
      end
      if (MEM_REQ && MEM_RDY) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got wr=%0d addr=0x%0h required none", MEM_WR, MEM_ADDR);
        end else begin
          exp = req_q.pop_front();
          check("req_wr", MEM_WR, exp.wr);
          check("req_addr", MEM_ADDR, exp.addr);
          check("req_be", MEM_BE, exp.be);
          if (exp.wr) check("req_wdata", MEM_WDATA, exp.wdata);
          check("req_stable", first, {MEM_WR, MEM_ADDR, MEM_BE, MEM_WDATA});
        end
      end
      prev_rdy = MEM_REQ && MEM_RDY;
      prev_req = MEM_REQ;
    end
  end

  // Read monitor: DO is compared whenever a CPU read completes
  initial begin
    forever begin
      @(rd_done_ev);
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got DO=0x%0h required no read", DO);
      end else begin
        check("read_do", DO, rd_q.pop_front());
      end
    end
  end

  task automatic cpu_read(input string name, input logic [ADDR_W-1:0] addr,
                          input logic [15:0] exp_do, input bit hit, input int exp_low);
    int low = 0;
    int rises0;
    rd_q.push_back(exp_do);
    if (!hit) req_q.push_back(req_t'{1'b0, addr, 2'b11, 16'h0});
    rises0 = req_rises;
    @(posedge CLK); #1;
    A     = addr;
    DOE_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    while (!DWAIT_N && low < 60) begin
      low++;
      @(negedge CLK);
    end
    #1;
    if (!DWAIT_N) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got DWAIT_N=0 required 1 within 60 cycles", name);
    end else begin
      -> rd_done_ev;
    end
    check({name, "_wait_cycles"}, low, exp_low);
    if (hit) check({name, "_no_req"}, req_rises - rises0, 0);
    @(posedge CLK); #1;
    DOE_N = 1'b1;
  endtask

  task automatic cpu_write(input string name, input logic [ADDR_W-1:0] addr,
                           input logic [15:0] data, input logic [1:0] dwe,
                           input logic [1:0] exp_be, input int exp_low);
    int low = 0;
    req_q.push_back(req_t'{1'b1, addr, exp_be, data});
    @(posedge CLK); #1;
    A     = addr;
    DI    = data;
    DWE_N = dwe;
    @(posedge CLK);
    @(negedge CLK);
    while (!DWAIT_N && low < 60) begin
      low++;
      @(negedge CLK);
    end
    #1;
    if (!DWAIT_N) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got DWAIT_N=0 required 1 within 60 cycles", name);
    end
    check({name, "_wait_cycles"}, low, exp_low);
    @(posedge CLK); #1;
    DWE_N = 2'b11;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before 500000");
    $fatal(1);
  end

  initial begin
    int rises0;
    mem[32'h10] = 16'hBEEF;
    mem[32'h20] = 16'h4321;
    RST_N = 1'b0;
    A     = '0;
    DI    = 16'h0;
    DCE_N = 1'b0;
    DOE_N = 1'b1;
    DWE_N = 2'b11;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_dwait_n", DWAIT_N, 1'b1);
    check("rst_do", DO, 16'h0);
    check("rst_mem_req", MEM_REQ, 1'b0);
    check("rst_mem_wr", MEM_WR, 1'b0);

    cpu_read("rd_miss_10", 19'h00010, 16'hBEEF, 1'b0, 5);
    cpu_read("rd_hit_10", 19'h00010, 16'hBEEF, 1'b1, 0);

    cpu_write("wr_upper_10", 19'h00010, 16'h1234, 2'b01, 2'b10, 0);
    repeat (12) @(posedge CLK);
    cpu_read("rd_merged_10", 19'h00010, 16'h12EF, 1'b1, 0);

    cpu_write("wr_30", 19'h00030, 16'hCAFE, 2'b00, 2'b11, 0);
    cpu_read("rd_behind_wr", 19'h00020, 16'h4321, 1'b0, 8);
    repeat (4) @(posedge CLK);

    cpu_write("wr_b2b_1", 19'h00001, 16'hAAAA, 2'b00, 2'b11, 0);
    cpu_write("wr_b2b_2", 19'h00002, 16'h5555, 2'b00, 2'b11, 2);
    repeat (15) @(posedge CLK);
    cpu_read("rd_02", 19'h00002, 16'h5555, 1'b0, 5);
    cpu_read("rd_01", 19'h00001, 16'hAAAA, 1'b0, 5);

    cpu_write("wr_lower_01", 19'h00001, 16'h77BB, 2'b10, 2'b01, 0);
    repeat (12) @(posedge CLK);
    cpu_read("rd_merged_01", 19'h00001, 16'hAABB, 1'b1, 0);

    // Unsolicited MEM_RDY while idle
    @(posedge CLK); #1 stray = 1'b1;
    @(posedge CLK); #1 stray = 1'b0;
    @(negedge CLK);
    check("stray_idle_do", DO, 16'hAABB);
    check("stray_idle_dwait_n", DWAIT_N, 1'b1);
    check("stray_idle_mem_req", MEM_REQ, 1'b0);

    // Read strobe without chip enable must not start an access
    rises0 = req_rises;
    @(posedge CLK); #1;
    DCE_N = 1'b1;
    A     = 19'h00040;
    DOE_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("no_dce_dwait_n", DWAIT_N, 1'b1);
    check("no_dce_no_req", req_rises - rises0, 0);
    @(posedge CLK); #1;
    DOE_N = 1'b1;
    DCE_N = 1'b0;

    // Reset in the middle of a read miss, then a late MEM_RDY
    @(posedge CLK); #1;
    A     = 19'h00040;
    DOE_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("pre_rst_dwait_n", DWAIT_N, 1'b0);
    @(posedge CLK); #1 RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    DOE_N = 1'b1;
    @(negedge CLK);
    check("mid_rst_dwait_n", DWAIT_N, 1'b1);
    check("mid_rst_do", DO, 16'h0);
    check("mid_rst_mem_req", MEM_REQ, 1'b0);
    @(posedge CLK); #1 stray = 1'b1;
    @(posedge CLK); #1 stray = 1'b0;
    repeat (2) @(negedge CLK);
    check("late_rdy_do", DO, 16'h0);
    check("late_rdy_dwait_n", DWAIT_N, 1'b1);
    check("late_rdy_mem_req", MEM_REQ, 1'b0);

    // Read buffer was invalidated, so 0x00001 must go to memory again
    cpu_read("rd_after_rst", 19'h00001, 16'hAABB, 1'b0, 5);

    repeat (10) @(posedge CLK);
    check("req_q_drained", req_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
